nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_if.sv | 14 +
 rtl/nibble_serial_adder.sv | 71 +++++++
 tb/tb_nibble_serial_adder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: start/operand request and busy/done/result response bundle
interface nibble_serial_adder_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic cin;
  logic busy;
  logic done;
  logic [W-1:0] sum;
  logic cout;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder reusing one 4-bit ripple adder, one nibble per clock, LSB first
module ripple_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module nibble_serial_adder #(parameter int NIBBLES = 4) (
  input logic clock,
  input logic reset,
  nibble_serial_adder_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] opa, opb, work, work_n, sum_q;
  logic [IW-1:0] idx;
  logic carry, cout_q, c4, last, accept;
  logic [3:0] s;
  ripple_add4 u_add (.a(opa[3:0]), .b(opb[3:0]), .cin(carry), .s(s), .cout(c4));
  assign last   = idx == IW'(NIBBLES - 1);
  assign accept = bus.start && state != ADD;
  always_comb begin
    state_n = state == ADD ? (last ? DONE : ADD) : (bus.start ? ADD : IDLE);
    work_n  = work;
    work_n[4*idx +: 4] = s;
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  // sum/cout only move on the final nibble, so partial results never leak out
  always_ff @(posedge clock) begin
    if (reset) begin
      opa    <= '0;
      opb    <= '0;
      work   <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      opa   <= bus.a;
      opb   <= bus.b;
      carry <= bus.cin;
      idx   <= '0;
    end else if (state == ADD) begin
      work  <= work_n;
      carry <= c4;
      opa   <= opa >> 4;
      opb   <= opb >> 4;
      idx   <= idx + 1'b1;
      if (last) begin
        sum_q  <= work_n;
        cout_q <= c4;
      end
    end
  end
  assign bus.busy = state == ADD;
  assign bus.done = state == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of the serial adder against plain a+b+cin
module tb_nibble_serial_adder;
  logic clock;
  logic reset;
  int errors = 0;
  int checks = 0;
  nibble_serial_adder_if #(.NIBBLES(4)) bus ();
  nibble_serial_adder #(.NIBBLES(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // pulses start once, scrambles operands afterwards, returns at the done cycle (or after a bound)
  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                       output logic [15:0] s, output logic co, output int lat, output int bc,
                       output bit changed, output bit overlap);
    logic [15:0] prev;
    int k;
    prev = bus.sum;
    bus.start = 1'b1; bus.a = oa; bus.b = ob; bus.cin = oc;
    @(posedge clock); #1;
    bus.start = 1'b0;
    k = 1; bc = 0; changed = 1'b0; overlap = 1'b0;
    while (!bus.done && k < 20) begin
      if (bus.busy) bc++;
      if (bus.sum !== prev) changed = 1'b1;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      k++;
    end
    overlap = bus.busy && bus.done;
    s = bus.sum; co = bus.cout; lat = k;
  endtask

  task automatic test_reset;
    int k;
    reset = 1'b1; bus.start = 1'b0; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.sum !== 16'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
    reset = 1'b0; bus.start = 1'b1; bus.a = 16'h0102; bus.b = 16'h0304; bus.cin = 1'b0;
    @(posedge clock); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL first_edge_start busy got=%b exp=1", bus.busy); end
    k = 0;
    while (!bus.done && k < 20) begin @(posedge clock); #1; k++; end
    checks++;
    if ({bus.cout, bus.sum} !== 17'h00406 || k != 4)
      begin errors++; $display("FAIL first_edge_result got=%h wait=%0d exp=00406 wait=4", {bus.cout, bus.sum}, k); end
    @(posedge clock); #1;
  endtask

  task automatic test_vectors;
    logic [15:0] va [6] = '{16'hFFFF, 16'h1234, 16'h0FFF, 16'h0000, 16'h8000, 16'hFFFF};
    logic [15:0] vb [6] = '{16'h0001, 16'h4321, 16'h0001, 16'h0000, 16'h8000, 16'hFFFF};
    logic        vc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [16:0] ve [6] = '{17'h10000, 17'h05556, 17'h01000, 17'h00000, 17'h10000, 17'h1FFFF};
    logic [15:0] s; logic co; int lat, bc; bit ch, ov;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vc[i], s, co, lat, bc, ch, ov);
      checks++; if ({co, s} !== ve[i]) begin errors++; $display("FAIL vec%0d_result got=%h exp=%h", i, {co, s}, ve[i]); end
      checks++; if (lat != 5) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=5", i, lat); end
      checks++; if (bc != 4) begin errors++; $display("FAIL vec%0d_busy_cycles got=%0d exp=4", i, bc); end
      checks++; if (ch || ov) begin errors++; $display("FAIL vec%0d_sum_early=%b busy_with_done=%b exp=0,0", i, ch, ov); end
      @(posedge clock); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL vec%0d_done_pulse got=%b exp=0", i, bus.done); end
    end
  endtask

  task automatic test_start_held;
    logic [15:0] prev, s; logic co; int dones; bit stable, seen;
    prev = bus.sum;
    bus.start = 1'b1; bus.a = 16'h7A5C; bus.b = 16'h39E8; bus.cin = 1'b1;
    @(posedge clock); #1;
    dones = 0; stable = 1'b1; seen = 1'b0; s = '0; co = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.done) begin dones++; seen = 1'b1; s = bus.sum; co = bus.cout; end
      else if (!seen && bus.sum !== prev) stable = 1'b0;
      bus.start = k < 5; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL held_done_count got=%0d exp=1", dones); end
    checks++; if ({co, s} !== 17'h0B445) begin errors++; $display("FAIL held_result got=%h exp=0b445", {co, s}); end
    checks++; if (!stable) begin errors++; $display("FAIL held_sum_stable got=changed exp=stable"); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s; logic co; int lat, bc; bit ch, ov;
    do_op(16'hF00F, 16'h1FF1, 1'b0, s, co, lat, bc, ch, ov);
    checks++; if ({co, s} !== 17'h11000 || bus.done !== 1'b1)
      begin errors++; $display("FAIL b2b_first got=%h done=%b exp=11000 done=1", {co, s}, bus.done); end
    do_op(16'h0001, 16'h0002, 1'b0, s, co, lat, bc, ch, ov);
    checks++; if ({co, s} !== 17'h00003) begin errors++; $display("FAIL b2b_second got=%h exp=00003", {co, s}); end
    checks++; if (lat != 5 || bc != 4) begin errors++; $display("FAIL b2b_timing lat=%0d busy=%0d exp 5/4", lat, bc); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_abort;
    logic [15:0] s; logic co; int lat, bc, dones; bit ch, ov;
    do_op(16'h1111, 16'h2222, 1'b0, s, co, lat, bc, ch, ov);
    @(posedge clock); #1;
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if ({bus.busy, bus.done, bus.cout, bus.sum} !== 19'h0)
      begin errors++; $display("FAIL abort_outputs busy=%b done=%b cout=%b sum=%h exp all 0", bus.busy, bus.done, bus.cout, bus.sum); end
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done) dones++;
      @(posedge clock); #1;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    do_op(16'h00FF, 16'h0F01, 1'b0, s, co, lat, bc, ch, ov);
    checks++; if ({co, s} !== 17'h01000 || lat != 5) begin errors++; $display("FAIL abort_restart got=%h lat=%0d exp=01000 lat=5", {co, s}, lat); end
    @(posedge clock); #1;
  endtask

  task automatic test_random;
    logic [15:0] ra, rb, s; logic rc, co; logic [16:0] exp; int lat, bc; bit ch, ov;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      exp = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      do_op(ra, rb, rc, s, co, lat, bc, ch, ov);
      checks++; if ({co, s} !== exp) begin errors++; $display("FAIL rand%0d %h+%h+%b got=%h exp=%h", i, ra, rb, rc, {co, s}, exp); end
      checks++; if (lat != 5 || bc != 4 || ch || ov)
        begin errors++; $display("FAIL rand%0d_timing lat=%0d busy=%0d early=%b ovl=%b exp 5/4/0/0", i, lat, bc, ch, ov); end
      if ($urandom_range(0, 1) == 1) begin @(posedge clock); #1; end
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_start_held;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
